fpu_result_arbiter: RTL
=======================

// Module: fpu_result_arbiter
// PURPOSE
// - Shares the single result sign-selection/packing stage between two FPU producers:
//   - the fixed-latency add/mul pipe (PIPE);
//   - the iterative div/sqrt unit (ITER).
// - Picks one request per cycle and registers it into a one-entry output stage.
// - The output stage drives the result sign selector and final packing with a valid/ready handshake.
// - PIPE is favoured; a starvation guard forces an ITER grant after STARVE_LIMIT consecutive losses.
// PARAMETERS
// - TAG_W        default 4   width of the per-operation tag carried with each result
// - STARVE_LIMIT default 3   consecutive ITER losses before ITER is forced; legal range 1..15
// - CNT_W        default 16  width of the grant counters (FPU_ARB_STATS_EN only)
// PORTS
// - clk               in   1      single clock, rising edge
// - reset             in   1      asynchronous, active-high
// - pipe_valid        in   1      PIPE request present
// - pipe_ready        out  1      PIPE request accepted this cycle
// - pipe_sign_select  in   3      sign::sign_select for the PIPE result
// - pipe_sign_a/_b    in   1 ea   operand signs, PIPE
// - pipe_result_sign  in   1      computed sign, PIPE
// - pipe_payload      in   31     exponent+mantissa bits [30:0], PIPE
// - pipe_tag          in   TAG_W  operation tag, PIPE
// - iter_*            -    -      same seven signals as pipe_*, for the ITER producer
// - out_valid         out  1      output stage holds a result
// - out_ready         in   1      downstream accepts the output this cycle
// - out_sign_select   out  3      registered sign_select
// - out_sign_a/_b     out  1 ea   registered operand signs
// - out_result_sign   out  1      registered computed sign
// - out_payload       out  31     registered payload
// - out_tag           out  TAG_W  registered tag
// - out_src           out  1      0 = PIPE, 1 = ITER
// - pipe_grant_cnt    out  CNT_W  PIPE grant count (FPU_ARB_STATS_EN only)
// - iter_grant_cnt    out  CNT_W  ITER grant count (FPU_ARB_STATS_EN only)
// BEHAVIOUR
// - Reset values:
//   - out_valid = 0; out_sign_select = sign::ZERO; all other out_* = 0.
//   - state = PIPE_FAV; starve_cnt = 0; counters = 0.
// - load_en = ~out_valid | out_ready. No grant is given when load_en = 0, so both readys are 0.
// - States:
//   - PIPE_FAV: grant PIPE if pipe_valid, else ITER if iter_valid.
//   - ITER_FORCE: grant ITER if iter_valid, else PIPE if pipe_valid.
// - starve_cnt (4 bit):
//   - increments when load_en & iter_valid & PIPE granted;
//   - clears on any ITER grant;
//   - holds otherwise.
// - State transitions:
//   - PIPE_FAV -> ITER_FORCE on the edge where starve_cnt reaches STARVE_LIMIT;
//   - ITER_FORCE -> PIPE_FAV on an ITER grant.
// - ready outputs are combinational from the grant: at most one of pipe_ready/iter_ready is high per cycle.
// - Latency: a request accepted in cycle N appears with out_valid = 1 in cycle N+1.
// - Throughput: one result per cycle when out_ready = 1.
// - Simultaneous drain and load (out_valid & out_ready & a grant): the output register is overwritten with the new
//   entry and out_valid stays 1, with no bubble.
// - Drain with no request: out_valid -> 0 the next cycle.
// - Backpressure (out_valid & ~out_ready): every out_* holds stable, no grant, starve_cnt holds.
// - Producers must hold valid and data stable until ready. Dropping valid before acceptance is a protocol error:
//   - flagged by an assertion in simulation;
//   - RTL behaviour is still defined: counters hold.
// - Reset asserted mid-operation: all state returns to reset values immediately. A held output is discarded.
// - out_sign_select is passed through unmodified. Decoding is done by the downstream selector.
// CONFIGURATION
// - Macro FPU_ARB_STATS_EN defined:
//   - pipe_grant_cnt/iter_grant_cnt exist;
//   - each increments by 1 on its grant and wraps to 0 after all-ones;
//   - both are cleared by reset.
// - Macro undefined: both counter ports and their logic are absent. Arbitration is identical either way.
// TESTING
// - Reset: pulse reset mid-stream -> out_valid = 0, out_sign_select = ZERO and readys drop in the same cycle;
//   first grant after release goes to PIPE when both are valid.
// - PIPE only, out_ready = 1, tags 1,2,3 in back-to-back cycles -> out_tag 1,2,3 on the next three cycles,
//   out_src = 0, no bubbles.
// - Both valid continuously, STARVE_LIMIT = 3, out_ready = 1 -> grant sequence P,P,P,I,P,P,P,I; out_src follows it
//   one cycle later.
// - out_ready low for 4 cycles with an ITER result held (tag 5, sign_select A_NB) -> outputs stable for all 4 cycles,
//   pipe_ready = iter_ready = 0, starve_cnt unchanged.
// - ITER alone in ITER_FORCE, then PIPE alone -> ITER granted first, state returns to PIPE_FAV, PIPE granted next
//   with no idle cycle.
// - FPU_ARB_STATS_EN, 10 PIPE + 4 ITER grants -> pipe_grant_cnt = 10, iter_grant_cnt = 4; preload the counter to
//   all-ones and grant once -> wraps to 0.

Source files
------------

// File: rtl/fpu_result_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_result_arbiter
// Brief    : Arbitrates PIPE/ITER FPU results into a one-entry output stage.
//            Optional grant counters: define FPU_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_result_arbiter #(
    parameter int TAG_W        = 4,
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pipe_valid,
    output logic             pipe_ready,
    input  logic [2:0]       pipe_sign_select,
    input  logic             pipe_sign_a,
    input  logic             pipe_sign_b,
    input  logic             pipe_result_sign,
    input  logic [30:0]      pipe_payload,
    input  logic [TAG_W-1:0] pipe_tag,
    input  logic             iter_valid,
    output logic             iter_ready,
    input  logic [2:0]       iter_sign_select,
    input  logic             iter_sign_a,
    input  logic             iter_sign_b,
    input  logic             iter_result_sign,
    input  logic [30:0]      iter_payload,
    input  logic [TAG_W-1:0] iter_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_sign_select,
    output logic             out_sign_a,
    output logic             out_sign_b,
    output logic             out_result_sign,
    output logic [30:0]      out_payload,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_src
`ifdef FPU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] pipe_grant_cnt,
    output logic [CNT_W-1:0] iter_grant_cnt
`endif
);

    typedef enum logic [0:0] {
        PIPE_FAV   = 1'b0,
        ITER_FORCE = 1'b1
    } state_t;

    localparam logic [2:0] SIGN_ZERO = 3'b000;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || CNT_W < 1 || TAG_W < 1) begin : g_param_check
        $error("fpu_result_arbiter: illegal parameter value");
    end

    state_t             state_q, state_d;
    logic [3:0]         starve_q, starve_d;
    logic               out_valid_q, out_valid_d;
    logic [2:0]         out_sign_select_q, out_sign_select_d;
    logic               out_sign_a_q, out_sign_a_d;
    logic               out_sign_b_q, out_sign_b_d;
    logic               out_result_sign_q, out_result_sign_d;
    logic [30:0]        out_payload_q, out_payload_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic               out_src_q, out_src_d;

    logic               load_en;
    logic               grant_pipe;
    logic               grant_iter;
    logic               starve_inc;

    assign load_en = ~out_valid_q | out_ready;

    always_comb begin
        grant_pipe        = 1'b0;
        grant_iter        = 1'b0;
        starve_inc        = 1'b0;
        state_d           = state_q;
        starve_d          = starve_q;
        out_valid_d       = out_valid_q;
        out_sign_select_d = out_sign_select_q;
        out_sign_a_d      = out_sign_a_q;
        out_sign_b_d      = out_sign_b_q;
        out_result_sign_d = out_result_sign_q;
        out_payload_d     = out_payload_q;
        out_tag_d         = out_tag_q;
        out_src_d         = out_src_q;

        if (load_en) begin
            case (state_q)
                PIPE_FAV: begin
                    if (pipe_valid)      grant_pipe = 1'b1;
                    else if (iter_valid) grant_iter = 1'b1;
                end
                ITER_FORCE: begin
                    if (iter_valid)      grant_iter = 1'b1;
                    else if (pipe_valid) grant_pipe = 1'b1;
                end
                default: ;
            endcase
            out_valid_d = grant_pipe | grant_iter;
        end

        if (grant_pipe) begin
            out_sign_select_d = pipe_sign_select;
            out_sign_a_d      = pipe_sign_a;
            out_sign_b_d      = pipe_sign_b;
            out_result_sign_d = pipe_result_sign;
            out_payload_d     = pipe_payload;
            out_tag_d         = pipe_tag;
            out_src_d         = 1'b0;
        end else if (grant_iter) begin
            out_sign_select_d = iter_sign_select;
            out_sign_a_d      = iter_sign_a;
            out_sign_b_d      = iter_sign_b;
            out_result_sign_d = iter_result_sign;
            out_payload_d     = iter_payload;
            out_tag_d         = iter_tag;
            out_src_d         = 1'b1;
        end

        // Saturate so an unreachable overflow can never wrap back below the limit.
        if (grant_iter) begin
            starve_d = 4'd0;
        end else if (grant_pipe && iter_valid && starve_q != 4'hF) begin
            starve_inc = 1'b1;
            starve_d   = starve_q + 4'd1;
        end

        case (state_q)
            PIPE_FAV:   if (starve_inc && starve_d == 4'(STARVE_LIMIT)) state_d = ITER_FORCE;
            ITER_FORCE: if (grant_iter) state_d = PIPE_FAV;
            default:    state_d = PIPE_FAV;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= PIPE_FAV;
            starve_q          <= 4'd0;
            out_valid_q       <= 1'b0;
            out_sign_select_q <= SIGN_ZERO;
            out_sign_a_q      <= 1'b0;
            out_sign_b_q      <= 1'b0;
            out_result_sign_q <= 1'b0;
            out_payload_q     <= '0;
            out_tag_q         <= '0;
            out_src_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            starve_q          <= starve_d;
            out_valid_q       <= out_valid_d;
            out_sign_select_q <= out_sign_select_d;
            out_sign_a_q      <= out_sign_a_d;
            out_sign_b_q      <= out_sign_b_d;
            out_result_sign_q <= out_result_sign_d;
            out_payload_q     <= out_payload_d;
            out_tag_q         <= out_tag_d;
            out_src_q         <= out_src_d;
        end
    end

    // Readys drop as soon as reset rises, not one edge later.
    assign pipe_ready      = grant_pipe & ~reset;
    assign iter_ready      = grant_iter & ~reset;
    assign out_valid       = out_valid_q;
    assign out_sign_select = out_sign_select_q;
    assign out_sign_a      = out_sign_a_q;
    assign out_sign_b      = out_sign_b_q;
    assign out_result_sign = out_result_sign_q;
    assign out_payload     = out_payload_q;
    assign out_tag         = out_tag_q;
    assign out_src         = out_src_q;

`ifdef FPU_ARB_STATS_EN
    logic [CNT_W-1:0] pipe_cnt_q;
    logic [CNT_W-1:0] iter_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_cnt_q <= '0;
            iter_cnt_q <= '0;
        end else begin
            if (grant_pipe) pipe_cnt_q <= pipe_cnt_q + CNT_W'(1);
            if (grant_iter) iter_cnt_q <= iter_cnt_q + CNT_W'(1);
        end
    end

    assign pipe_grant_cnt = pipe_cnt_q;
    assign iter_grant_cnt = iter_cnt_q;
`endif

    a_pipe_valid_hold: assert property (@(posedge clk) disable iff (reset)
        (pipe_valid && !pipe_ready) |=> pipe_valid);
    a_iter_valid_hold: assert property (@(posedge clk) disable iff (reset)
        (iter_valid && !iter_ready) |=> iter_valid);

endmodule
`default_nettype wire
